// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared widths, reset/bubble constants and next-PC source encoding
package pipeline_pkg;
    localparam int WORD_W = 32;
    localparam logic [WORD_W-1:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [WORD_W-1:0] RESET_PC = 32'h0000_0000;
    typedef enum logic [1:0] {PCSRC_HOLD, PCSRC_SEQ, PCSRC_REDIRECT} pcSrc_e;
endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: hazard-unit controls, instruction-memory port, IF/ID outputs and perf counters
interface fetch_stage_if #(parameter int IMEM_AW = 10);
    import pipeline_pkg::*;
    logic stall;
    logic bubif;
    logic halt_req;
    logic [WORD_W-1:0] redirect_pc;
    logic [WORD_W-1:0] imem_rdata;
    logic [IMEM_AW-1:0] imem_addr;
    logic [WORD_W-1:0] pc_if;
    logic [WORD_W-1:0] ifid_instr;
    logic [WORD_W-1:0] ifid_pc4;
    logic ifid_valid;
    logic halted;
    logic [WORD_W-1:0] fetch_cnt;
    logic [WORD_W-1:0] stall_cnt;
    logic [WORD_W-1:0] flush_cnt;
    modport master (
        input stall, bubif, halt_req, redirect_pc, imem_rdata,
        output imem_addr, pc_if, ifid_instr, ifid_pc4, ifid_valid, halted,
        output fetch_cnt, stall_cnt, flush_cnt
    );
    modport slave (
        output stall, bubif, halt_req, redirect_pc, imem_rdata,
        input imem_addr, pc_if, ifid_instr, ifid_pc4, ifid_valid, halted,
        input fetch_cnt, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/perf_counter.sv
// perf_counter: enable-gated free-running counter that wraps at 2^WORD_W
module perf_counter
    import pipeline_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    output logic [WORD_W-1:0] count
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) count <= '0;
        else if (en) count <= count + 1'b1;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, next-PC select, IF/ID register, sticky halt and perf counters
module fetch_stage
    import pipeline_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = pipeline_pkg::RESET_PC,
    parameter int IMEM_AW = 10,
    parameter logic [WORD_W-1:0] NOP_INSTR = pipeline_pkg::NOP_INSTR
) (
    input logic clk,
    input logic rst_n,
    fetch_stage_if.master bus
);
    logic [WORD_W-1:0] pc, pcNext, pcPlus4, ifidInstr, ifidPc4;
    logic ifidValid, halted, active, bubble, loadIfid;
    pcSrc_e pcSrc;
    // active: this edge is not swallowed by an existing or incoming halt
    assign active = !halted && !bus.halt_req;
    assign bubble = !halted && (bus.halt_req || bus.bubif);
    assign pcPlus4 = pc + 32'd4;
    always_comb begin
        pcSrc = PCSRC_HOLD;
        if (active && bus.bubif) pcSrc = PCSRC_REDIRECT;
        else if (active && !bus.stall) pcSrc = PCSRC_SEQ;
    end
    assign loadIfid = pcSrc == PCSRC_SEQ;
    assign pcNext = pcSrc == PCSRC_REDIRECT ? (bus.redirect_pc & ~32'h3) :
                    pcSrc == PCSRC_SEQ ? pcPlus4 : pc;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) pc <= RESET_PC & ~32'h3;
        else pc <= pcNext;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            ifidInstr <= NOP_INSTR;
            ifidPc4 <= '0;
            ifidValid <= 1'b0;
        end else if (bubble) begin
            ifidInstr <= NOP_INSTR;
            ifidPc4 <= '0;
            ifidValid <= 1'b0;
        end else if (loadIfid) begin
            ifidInstr <= bus.imem_rdata;
            ifidPc4 <= pcPlus4;
            ifidValid <= 1'b1;
        end else if (halted) begin
            ifidValid <= 1'b0;
        end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) halted <= 1'b0;
        else if (bus.halt_req) halted <= 1'b1;
    perf_counter uFetchCnt (.clk(clk), .rst_n(rst_n), .en(loadIfid), .count(bus.fetch_cnt));
    perf_counter uStallCnt (.clk(clk), .rst_n(rst_n), .en(active && bus.stall), .count(bus.stall_cnt));
    perf_counter uFlushCnt (.clk(clk), .rst_n(rst_n), .en(active && bus.bubif), .count(bus.flush_cnt));
    assign bus.imem_addr = pc[IMEM_AW+1:2];
    assign bus.pc_if = pc;
    assign bus.ifid_instr = ifidInstr;
    assign bus.ifid_pc4 = ifidPc4;
    assign bus.ifid_valid = ifidValid;
    assign bus.halted = halted;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed plus random stimulus checked against a behavioural fetch model
module tb_fetch_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [31:0] imem [1024];
    int nChecks = 0;
    int nFails = 0;
    logic [31:0] mPc, mInstr, mPc4, mFetch, mStall, mFlush;
    logic mValid, mHalted;

    fetch_stage_if #(.IMEM_AW(10)) bus ();
    fetch_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus.master));

    always #5 clk = ~clk;
    assign bus.imem_rdata = imem[bus.imem_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nFails++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mPc = 32'h0; mInstr = 32'h0; mPc4 = 32'h0; mValid = 1'b0; mHalted = 1'b0;
        mFetch = 0; mStall = 0; mFlush = 0;
    endtask

    // one rising edge of the fetch stage as described by its priority rules
    task automatic modelEdge();
        if (mHalted) mValid = 1'b0;
        else if (bus.halt_req) begin
            mHalted = 1'b1; mInstr = 32'h0; mPc4 = 32'h0; mValid = 1'b0;
        end else if (bus.bubif) begin
            mInstr = 32'h0; mPc4 = 32'h0; mValid = 1'b0; mFlush++;
            if (bus.stall) mStall++;
            mPc = {bus.redirect_pc[31:2], 2'b00};
        end else if (bus.stall) mStall++;
        else begin
            mInstr = imem[mPc[11:2]]; mPc4 = mPc + 4; mValid = 1'b1; mFetch++; mPc = mPc + 4;
        end
    endtask

    task automatic checkAll(input string tag);
        check({tag, ".pc"}, bus.pc_if, mPc);
        check({tag, ".addr"}, {22'h0, bus.imem_addr}, {22'h0, mPc[11:2]});
        check({tag, ".instr"}, bus.ifid_instr, mInstr);
        check({tag, ".pc4"}, bus.ifid_pc4, mPc4);
        check({tag, ".valid"}, {31'h0, bus.ifid_valid}, {31'h0, mValid});
        check({tag, ".halted"}, {31'h0, bus.halted}, {31'h0, mHalted});
        check({tag, ".fcnt"}, bus.fetch_cnt, mFetch);
        check({tag, ".scnt"}, bus.stall_cnt, mStall);
        check({tag, ".bcnt"}, bus.flush_cnt, mFlush);
    endtask

    task automatic drive(input bit s, input bit b, input bit h, input logic [31:0] r);
        bus.stall = s; bus.bubif = b; bus.halt_req = h; bus.redirect_pc = r;
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        modelEdge();
        #1 checkAll(tag);
    endtask

    task automatic doReset(input string tag);
        rst_n = 1'b0;
        #3 modelReset();
        checkAll(tag);
        @(negedge clk) rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) imem[i] = i + 32'h100;
        drive(0, 0, 0, 0);
        #2 doReset("rst");
        check("rst.pcConst", bus.pc_if, 32'h0);
        check("rst.instrConst", bus.ifid_instr, 32'h0);
        for (int i = 0; i < 3; i++) step("run");
        check("run.pc", bus.pc_if, 32'h0C);
        check("run.instr", bus.ifid_instr, 32'h102);
        check("run.pc4", bus.ifid_pc4, 32'h0C);
        check("run.fcnt", bus.fetch_cnt, 32'd3);
        doReset("rst2");
        step("n"); step("n");
        drive(1, 0, 0, 0);
        step("stl"); step("stl");
        check("stl.pc", bus.pc_if, 32'h08);
        check("stl.instr", bus.ifid_instr, 32'h101);
        check("stl.valid", {31'h0, bus.ifid_valid}, 32'h1);
        check("stl.scnt", bus.stall_cnt, 32'd2);
        check("stl.fcnt", bus.fetch_cnt, 32'd2);
        drive(0, 0, 0, 0);
        step("res");
        check("res.instr", bus.ifid_instr, 32'h102);
        step("n");
        check("pre.pc", bus.pc_if, 32'h10);
        drive(0, 1, 0, 32'h40);
        step("bub");
        check("bub.pc", bus.pc_if, 32'h40);
        check("bub.valid", {31'h0, bus.ifid_valid}, 32'h0);
        check("bub.instr", bus.ifid_instr, 32'h0);
        check("bub.bcnt", bus.flush_cnt, 32'd1);
        drive(0, 0, 0, 0);
        step("post");
        check("post.instr", bus.ifid_instr, 32'h110);
        check("post.pc4", bus.ifid_pc4, 32'h44);
        drive(1, 1, 0, 32'h80);
        step("sb");
        check("sb.pc", bus.pc_if, 32'h80);
        check("sb.bcnt", bus.flush_cnt, 32'd2);
        check("sb.scnt", bus.stall_cnt, 32'd3);
        drive(0, 1, 0, 32'hFFFF_FFFF);
        step("wrp");
        check("wrp.pc", bus.pc_if, 32'hFFFF_FFFC);
        drive(0, 0, 0, 0);
        step("wrp2");
        check("wrp2.pc", bus.pc_if, 32'h0);
        check("wrp2.pc4", bus.ifid_pc4, 32'h0);
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, 0, $urandom);
            step("rnd");
        end
        drive(0, 0, 0, 0);
        doReset("rst3");
        for (int i = 0; i < 8; i++) step("n");
        drive(0, 0, 1, 0);
        step("hlt");
        check("hlt.pc", bus.pc_if, 32'h20);
        check("hlt.halted", {31'h0, bus.halted}, 32'h1);
        check("hlt.valid", {31'h0, bus.ifid_valid}, 32'h0);
        drive(1, 0, 0, 0); step("hs");
        drive(0, 1, 0, 32'h100); step("hb");
        drive(1, 1, 1, 32'h100); step("hsb");
        check("hsb.pc", bus.pc_if, 32'h20);
        check("hsb.fcnt", bus.fetch_cnt, 32'd8);
        check("hsb.scnt", bus.stall_cnt, 32'd0);
        check("hsb.bcnt", bus.flush_cnt, 32'd0);
        drive(0, 0, 0, 0);
        doReset("hrst");
        check("hrst.halted", {31'h0, bus.halted}, 32'h0);
        for (int i = 0; i < 3; i++) step("n");
        drive(1, 0, 0, 0);
        step("ms"); step("ms");
        #2 rst_n = 1'b0;
        #1 modelReset();
        checkAll("arst");
        check("arst.pc", bus.pc_if, 32'h0);
        @(negedge clk) rst_n = 1'b1;
        drive(0, 0, 0, 0);
        step("after"); step("after");
        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
        $finish;
    end
endmodule
